// File: rtl/fpu_issue_arbiter.sv
// fpu_issue_arbiter: shares one FPU datapath between two requesters using
// round-robin grants, one operation in flight, with a completion timeout.
module fpu_issue_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        sys_clk,
    input  logic        rstn,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [3:0]  req_op0,
    input  logic [3:0]  req_op1,
    input  logic [31:0] req_x1_0,
    input  logic [31:0] req_x1_1,
    input  logic [31:0] req_x2_0,
    input  logic [31:0] req_x2_1,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [9:0]  fpu_opcode,
    output logic [31:0] fpu_x1,
    output logic [31:0] fpu_x2,
    input  logic [31:0] fpu_y,
    input  logic        fpu_out_valid,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              rr_last_r;
    logic              tag_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [9:0]        fpu_opcode_r;
    logic [31:0]       fpu_x1_r;
    logic [31:0]       fpu_x2_r;
    logic [31:0]       rsp_data_r;
    logic [1:0]        rsp_valid_r;
    logic              rsp_err_r;
    logic              busy_r;

    logic              grant_s;
    logic              grant_valid_s;
    logic [1:0]        grant_onehot_s;
    logic [1:0]        tag_onehot_s;
    logic [1:0]        req_ready_s;
    logic [3:0]        sel_op_s;
    logic [31:0]       sel_x1_s;
    logic [31:0]       sel_x2_s;
    logic              op_legal_s;
    logic              timeout_s;
    logic              rsp_hs_s;

    function automatic logic [9:0] op_to_onehot(input logic [3:0] op);
        logic [9:0] oh;
        if (op <= 4'd9) begin
            oh = 10'd1 << op;
        end else begin
            oh = 10'd0;
        end
        return oh;
    endfunction

    // Round-robin grant; the port that did not win last time has priority on a tie
    always_comb begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
        if (state_r == ST_IDLE) begin
            case (req_valid)
                2'b01: begin
                    grant_s       = 1'b0;
                    grant_valid_s = 1'b1;
                end
                2'b10: begin
                    grant_s       = 1'b1;
                    grant_valid_s = 1'b1;
                end
                2'b11: begin
                    grant_s       = ~rr_last_r;
                    grant_valid_s = 1'b1;
                end
                default: begin
                    grant_s       = 1'b0;
                    grant_valid_s = 1'b0;
                end
            endcase
        end else begin
            grant_s       = 1'b0;
            grant_valid_s = 1'b0;
        end
    end

    assign grant_onehot_s = grant_s ? 2'b10 : 2'b01;
    assign tag_onehot_s   = tag_r ? 2'b10 : 2'b01;
    assign req_ready_s    = grant_valid_s ? grant_onehot_s : 2'b00;
    // Held low while reset is asserted so no requester sees an accept during reset
    assign req_ready      = req_ready_s & {2{rstn}};

    assign sel_op_s   = grant_s ? req_op1  : req_op0;
    assign sel_x1_s   = grant_s ? req_x1_1 : req_x1_0;
    assign sel_x2_s   = grant_s ? req_x2_1 : req_x2_0;
    assign op_legal_s = (sel_op_s <= 4'd9);
    assign timeout_s  = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign rsp_hs_s   = (state_r == ST_RESP) && rsp_ready[tag_r];

    // State register
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a completion in the same cycle as expiry wins over the timeout
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_valid_s) begin
                    state_next_s = op_legal_s ? ST_ISSUE : ST_RESP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = fpu_out_valid ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_out_valid || timeout_s) begin
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = rsp_hs_s ? ST_IDLE : ST_RESP;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Operation datapath: latch request, drive FPU, capture result or error
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            rr_last_r    <= 1'b1;
            tag_r        <= 1'b0;
            cnt_r        <= '0;
            fpu_opcode_r <= 10'd0;
            fpu_x1_r     <= 32'd0;
            fpu_x2_r     <= 32'd0;
            rsp_valid_r  <= 2'b00;
            rsp_data_r   <= 32'd0;
            rsp_err_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            fpu_opcode_r <= 10'd0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        tag_r     <= grant_s;
                        rr_last_r <= grant_s;
                        if (op_legal_s) begin
                            fpu_opcode_r <= op_to_onehot(sel_op_s);
                            fpu_x1_r     <= sel_x1_s;
                            fpu_x2_r     <= sel_x2_s;
                        end else begin
                            rsp_valid_r <= grant_onehot_s;
                            rsp_data_r  <= 32'd0;
                            rsp_err_r   <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_r <= '0;
                    if (fpu_out_valid) begin
                        rsp_valid_r <= tag_onehot_s;
                        rsp_data_r  <= fpu_y;
                        rsp_err_r   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (fpu_out_valid) begin
                        rsp_valid_r <= tag_onehot_s;
                        rsp_data_r  <= fpu_y;
                        rsp_err_r   <= 1'b0;
                    end else if (timeout_s) begin
                        rsp_valid_r <= tag_onehot_s;
                        rsp_data_r  <= 32'd0;
                        rsp_err_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_r <= 2'b00;
                        rsp_data_r  <= 32'd0;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_r <= 2'b00;
                    rsp_data_r  <= 32'd0;
                    rsp_err_r   <= 1'b0;
                end
            endcase
            busy_r <= (state_next_s != ST_IDLE);
        end
    end

    assign fpu_opcode = fpu_opcode_r;
    assign fpu_x1     = fpu_x1_r;
    assign fpu_x2     = fpu_x2_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_data   = rsp_data_r;
    assign rsp_err    = rsp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Testbench for fpu_issue_arbiter: a stand-in FPU with programmable latency and
// a transaction-level reference model of grants, latencies and responses.
module tb_fpu_issue_arbiter;

    localparam int T  = 64;
    localparam int CW = 7;

    logic        sys_clk = 1'b0;
    logic        rstn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [3:0]  req_op0, req_op1;
    logic [31:0] req_x1_0, req_x1_1, req_x2_0, req_x2_1;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [9:0]  fpu_opcode;
    logic [31:0] fpu_x1, fpu_x2;
    logic [31:0] fpu_y = 32'd0;
    logic        fpu_out_valid = 1'b0;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          fpu_lat = 0;
    int          fpu_cd = -1;
    logic [31:0] fpu_pend = 32'd0;
    logic        fpu_force = 1'b0;
    int          model_rr = 1;

    fpu_issue_arbiter #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .sys_clk(sys_clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_x1_0(req_x1_0), .req_x1_1(req_x1_1),
        .req_x2_0(req_x2_0), .req_x2_1(req_x2_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpu_opcode(fpu_opcode), .fpu_x1(fpu_x1), .fpu_x2(fpu_x2),
        .fpu_y(fpu_y), .fpu_out_valid(fpu_out_valid), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    // Stand-in FPU arithmetic: fabs is exact, one fadd case is exact, the rest is a tagged mix
    function automatic logic [31:0] fake_fpu(input logic [9:0] oh, input logic [31:0] a, input logic [31:0] b);
        if (oh == 10'h080) return a & 32'h7FFF_FFFF;
        if (oh == 10'h001 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a + b) ^ {22'd0, oh};
    endfunction

    // Stand-in FPU timing: answers fpu_lat cycles after the opcode pulse (0 = same cycle, <0 = never)
    always @(negedge sys_clk) begin
        fpu_out_valid = fpu_force;
        if (fpu_opcode != 10'd0) begin
            fpu_pend = fake_fpu(fpu_opcode, fpu_x1, fpu_x2);
            fpu_cd   = fpu_lat;
        end else if (fpu_cd > 0) begin
            fpu_cd = fpu_cd - 1;
        end
        if (fpu_cd == 0) begin
            fpu_out_valid = 1'b1;
            fpu_y         = fpu_pend;
            fpu_cd        = -1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // One transaction from a single port; gathers observations, compares nothing
    task automatic run_op(input logic port, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int hold,
                          output int lat_seen, output logic [1:0] rv, output logic [31:0] data,
                          output logic err, output int pulses, output logic [9:0] oh_seen,
                          output logic [1:0] rdy_seen, output logic stable, output logic cleared);
        bit acc;
        acc = 1'b0; lat_seen = -1; rv = 2'b00; data = 32'd0; err = 1'b0; pulses = 0;
        oh_seen = 10'd0; rdy_seen = 2'b00; stable = 1'b1; cleared = 1'b0;
        fpu_lat = lat;
        @(negedge sys_clk);
        if (port) begin
            req_op1 = op; req_x1_1 = a; req_x2_1 = b; req_valid = 2'b10;
        end else begin
            req_op0 = op; req_x1_0 = a; req_x2_0 = b; req_valid = 2'b01;
        end
        for (int w = 0; w < 50 && !acc; w++) begin
            #1;
            rdy_seen = req_ready;
            acc = (port ? req_ready[1] : req_ready[0]);
            @(negedge sys_clk);
        end
        req_valid = 2'b00;
        if (!acc) return;
        model_rr = port ? 1 : 0;
        for (int k = 1; k <= T + 10; k++) begin
            if (fpu_opcode != 10'd0) begin
                pulses++;
                oh_seen = fpu_opcode;
            end
            if (rsp_valid != 2'b00) begin
                lat_seen = k; rv = rsp_valid; data = rsp_data; err = rsp_err;
                break;
            end
            @(negedge sys_clk);
        end
        if (lat_seen < 0) return;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = ~rv;
            @(negedge sys_clk);
            if (rsp_valid !== rv || rsp_data !== data || rsp_err !== err) stable = 1'b0;
        end
        rsp_ready = rv;
        @(negedge sys_clk);
        rsp_ready = 2'b00;
        cleared = (rsp_valid === 2'b00) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 2'b11; rsp_ready = 2'b00;
        req_op0 = 4'd0; req_op1 = 4'd0;
        req_x1_0 = 32'd0; req_x1_1 = 32'd0; req_x2_0 = 32'd0; req_x2_1 = 32'd0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({rsp_valid, rsp_err, busy, fpu_opcode} !== 14'd0) begin
            errors++; $display("FAIL reset_ctrl got %h want 0", {rsp_valid, rsp_err, busy, fpu_opcode});
        end
        checks++;
        if ({rsp_data, fpu_x1, fpu_x2} !== 96'd0) begin
            errors++; $display("FAIL reset_data got %h want 0", {rsp_data, fpu_x1, fpu_x2});
        end
        checks++;
        if (req_ready !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b want 00", req_ready);
        end
        req_valid = 2'b00;
        rstn = 1'b1;
        model_rr = 1;
        @(negedge sys_clk);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++; $display("FAIL first_winner got %b want 01", req_ready);
        end
        req_valid = 2'b00;
        #1;
    endtask

    task automatic test_single();
        int l, p; logic [1:0] rv, rdy; logic [31:0] d; logic e, st, cl; logic [9:0] oh;
        run_op(1'b0, 4'd0, 32'h3F80_0000, 32'h4000_0000, 3, 2, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== 5) begin errors++; $display("FAIL single_latency got %0d want 5", l); end
        checks++;
        if ({rv, e, d} !== {2'b01, 1'b0, 32'h4040_0000}) begin
            errors++; $display("FAIL single_rsp got %b/%b/%h want 01/0/40400000", rv, e, d);
        end
        checks++;
        if (p !== 1 || oh !== 10'h001) begin
            errors++; $display("FAIL single_opcode got %0d pulses %h want 1 pulse 001", p, oh);
        end
        checks++;
        if ({rdy, st, cl} !== {2'b01, 1'b1, 1'b1}) begin
            errors++; $display("FAIL single_hs got rdy %b stable %b cleared %b want 01 1 1", rdy, st, cl);
        end
    endtask

    task automatic test_illegal();
        int l, p; logic [1:0] rv, rdy; logic [31:0] d; logic e, st, cl; logic [9:0] oh;
        run_op(1'b1, 4'd12, $urandom, $urandom, 0, 2, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", l); end
        checks++;
        if ({rv, e, d} !== {2'b10, 1'b1, 32'd0}) begin
            errors++; $display("FAIL illegal_rsp got %b/%b/%h want 10/1/0", rv, e, d);
        end
        checks++;
        if (p !== 0 || st !== 1'b1 || cl !== 1'b1) begin
            errors++; $display("FAIL illegal_fpu got pulses %0d stable %b cleared %b want 0 1 1", p, st, cl);
        end
    endtask

    task automatic test_timeout();
        int l, p; logic [1:0] rv, rdy; logic [31:0] d, a, b; logic e, st, cl; logic [9:0] oh;
        run_op(1'b0, 4'd3, $urandom, $urandom, -1, 1, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== T + 2 || {rv, e, d} !== {2'b01, 1'b1, 32'd0} || oh !== 10'h008) begin
            errors++; $display("FAIL timeout_never got lat %0d %b/%b/%h op %h want %0d 01/1/0 008", l, rv, e, d, oh, T + 2);
        end
        a = $urandom; b = $urandom;
        run_op(1'b1, 4'd2, a, b, T, 0, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== T + 2 || {rv, e, d} !== {2'b10, 1'b0, fake_fpu(10'h004, a, b)}) begin
            errors++; $display("FAIL timeout_last_cycle got lat %0d %b/%b/%h want %0d 10/0/%h", l, rv, e, d, T + 2, fake_fpu(10'h004, a, b));
        end
        run_op(1'b1, 4'd5, a, b, T + 1, 0, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== T + 2 || {rv, e, d} !== {2'b10, 1'b1, 32'd0}) begin
            errors++; $display("FAIL timeout_one_late got lat %0d %b/%b/%h want %0d 10/1/0", l, rv, e, d, T + 2);
        end
        run_op(1'b0, 4'd1, a, b, 2, 0, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== 4 || {rv, e, d} !== {2'b01, 1'b0, fake_fpu(10'h002, a, b)} || cl !== 1'b1) begin
            errors++; $display("FAIL timeout_recover got lat %0d %b/%b/%h want 4 01/0/%h", l, rv, e, d, fake_fpu(10'h002, a, b));
        end
    endtask

    task automatic test_fabs();
        int l, p; logic [1:0] rv, rdy; logic [31:0] d, a; logic e, st, cl; logic [9:0] oh;
        a = $urandom | 32'h8000_0000;
        run_op(1'b1, 4'd7, a, $urandom, 0, 0, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== 2 || {rv, e, d} !== {2'b10, 1'b0, a & 32'h7FFF_FFFF} || oh !== 10'h080) begin
            errors++; $display("FAIL fabs_zero_latency got lat %0d %b/%b/%h op %h want 2 10/0/%h 080", l, rv, e, d, oh, a & 32'h7FFF_FFFF);
        end
    endtask

    task automatic test_back_to_back();
        int grants, resps, cnt0, cnt1, exp_g;
        logic [31:0] exp_q[$];
        logic [1:0]  expv_q[$];
        logic [9:0]  oh;
        grants = 0; resps = 0; cnt0 = 0; cnt1 = 0;
        rsp_ready = 2'b11;
        @(negedge sys_clk);
        req_op0 = 4'($urandom_range(0, 9)); req_x1_0 = $urandom; req_x2_0 = $urandom;
        req_op1 = 4'($urandom_range(0, 9)); req_x1_1 = $urandom; req_x2_1 = $urandom;
        req_valid = 2'b11;
        for (int c = 0; c < 800 && resps < 8; c++) begin
            #1;
            if (rsp_valid != 2'b00) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected_rsp got %b want none", rsp_valid);
                end else begin
                    if ({rsp_valid, rsp_err, rsp_data} !== {expv_q[0], 1'b0, exp_q[0]}) begin
                        errors++; $display("FAIL b2b_rsp got %b/%b/%h want %b/0/%h", rsp_valid, rsp_err, rsp_data, expv_q[0], exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                    void'(expv_q.pop_front());
                end
                resps++;
            end
            if (req_ready != 2'b00) begin
                exp_g = (req_valid == 2'b11) ? 1 - model_rr : (req_valid[1] ? 1 : 0);
                checks++;
                if (req_ready !== (exp_g == 1 ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL b2b_grant got %b want port %0d", req_ready, exp_g);
                end
                oh = 10'd1 << (exp_g == 1 ? req_op1 : req_op0);
                exp_q.push_back(exp_g == 1 ? fake_fpu(oh, req_x1_1, req_x2_1) : fake_fpu(oh, req_x1_0, req_x2_0));
                expv_q.push_back(exp_g == 1 ? 2'b10 : 2'b01);
                model_rr = exp_g;
                fpu_lat = $urandom_range(0, 3);
                grants++;
                @(posedge sys_clk);
                #1;
                if (exp_g == 1) begin
                    cnt1++;
                    if (cnt1 == 4) req_valid[1] = 1'b0;
                    else begin req_op1 = 4'($urandom_range(0, 9)); req_x1_1 = $urandom; req_x2_1 = $urandom; end
                end else begin
                    cnt0++;
                    if (cnt0 == 4) req_valid[0] = 1'b0;
                    else begin req_op0 = 4'($urandom_range(0, 9)); req_x1_0 = $urandom; req_x2_0 = $urandom; end
                end
            end
            @(negedge sys_clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        checks++;
        if (grants !== 8 || resps !== 8) begin
            errors++; $display("FAIL b2b_count got %0d grants %0d rsps want 8 8", grants, resps);
        end
    endtask

    task automatic test_reset_mid();
        bit acc; int seen; logic [31:0] a, b;
        int l, p; logic [1:0] rv, rdy; logic [31:0] d; logic e, st, cl; logic [9:0] oh;
        acc = 1'b0; seen = 0; a = $urandom; b = $urandom;
        fpu_lat = -1;
        @(negedge sys_clk);
        req_op1 = 4'd4; req_x1_1 = a; req_x2_1 = b; req_valid = 2'b10;
        for (int w = 0; w < 20 && !acc; w++) begin
            #1;
            acc = req_ready[1];
            @(negedge sys_clk);
        end
        req_valid = 2'b00;
        repeat (4) @(negedge sys_clk);
        checks++;
        if ({busy, fpu_opcode, fpu_x1, fpu_x2} !== {1'b1, 10'd0, a, b}) begin
            errors++; $display("FAIL wait_hold got %b %h %h %h want 1 000 %h %h", busy, fpu_opcode, fpu_x1, fpu_x2, a, b);
        end
        #2;
        rstn = 1'b0;
        req_valid = 2'b11;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, busy, fpu_opcode, rsp_data, fpu_x1, fpu_x2} !== 112'd0) begin
            errors++; $display("FAIL async_reset got %b %b %b %b %h %h %h %h want all 0", req_ready, rsp_valid, rsp_err, busy, fpu_opcode, rsp_data, fpu_x1, fpu_x2);
        end
        @(negedge sys_clk);
        req_valid = 2'b00;
        @(negedge sys_clk);
        rstn = 1'b1;
        model_rr = 1;
        repeat (T + 8) begin
            @(negedge sys_clk);
            if (rsp_valid != 2'b00 || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abandoned_op got %0d active cycles want 0", seen); end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin errors++; $display("FAIL winner_after_reset got %b want 01", req_ready); end
        req_valid = 2'b00;
        #1;
        run_op(1'b1, 4'd6, a, b, 1, 0, l, rv, d, e, p, oh, rdy, st, cl);
        checks++;
        if (l !== 3 || {rv, e, d} !== {2'b10, 1'b0, fake_fpu(10'h040, a, b)}) begin
            errors++; $display("FAIL after_reset_op got lat %0d %b/%b/%h want 3 10/0/%h", l, rv, e, d, fake_fpu(10'h040, a, b));
        end
    endtask

    task automatic test_spurious();
        int seen;
        seen = 0;
        @(negedge sys_clk);
        fpu_force = 1'b1;
        repeat (3) begin
            @(negedge sys_clk);
            if (rsp_valid != 2'b00 || busy) seen++;
        end
        fpu_force = 1'b0;
        @(negedge sys_clk);
        checks++;
        if (seen !== 0 || rsp_valid !== 2'b00) begin
            errors++; $display("FAIL idle_out_valid got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_random();
        int lat_tab[8];
        int l, p, lat, hold, exp_l;
        logic port; logic [3:0] op; logic [31:0] a, b, d, exp_d;
        logic [1:0] rv, rdy, exp_v; logic e, exp_e, st, cl; logic [9:0] oh, exp_oh;
        lat_tab = '{0, 1, 2, 3, 5, T, T + 1, -1};
        for (int n = 0; n < 16; n++) begin
            port = 1'($urandom_range(0, 1));
            op   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            lat  = lat_tab[$urandom_range(0, 7)];
            hold = $urandom_range(0, 3);
            a = $urandom; b = $urandom;
            exp_v = port ? 2'b10 : 2'b01;
            exp_oh = 10'd0;
            if (op > 4'd9) begin
                exp_l = 1; exp_e = 1'b1; exp_d = 32'd0;
            end else begin
                exp_oh[op] = 1'b1;
                if (lat >= 0 && lat <= T) begin
                    exp_l = lat + 2; exp_e = 1'b0; exp_d = fake_fpu(exp_oh, a, b);
                end else begin
                    exp_l = T + 2; exp_e = 1'b1; exp_d = 32'd0;
                end
            end
            run_op(port, op, a, b, lat, hold, l, rv, d, e, p, oh, rdy, st, cl);
            checks++;
            if (l !== exp_l || {rv, e, d} !== {exp_v, exp_e, exp_d}) begin
                errors++; $display("FAIL rand_rsp op %0d lat %0d got %0d %b/%b/%h want %0d %b/%b/%h", op, lat, l, rv, e, d, exp_l, exp_v, exp_e, exp_d);
            end
            checks++;
            if (oh !== exp_oh || p !== (op > 4'd9 ? 0 : 1) || {rdy, st, cl} !== {exp_v, 1'b1, 1'b1}) begin
                errors++; $display("FAIL rand_ctrl op %0d got %h x%0d rdy %b st %b cl %b want %h", op, oh, p, rdy, st, cl, exp_oh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_illegal();
        test_timeout();
        test_fabs();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
